alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Execution-side consumer of the 3-bit ALUControl code produced by the ALU decoder.
//  Accepts operands plus ALUControl over a valid/ready handshake.
//  Computes the result and holds it in an output register until the downstream stage takes it.
//  Sits between the decode/register-read stage and writeback in the multi-cycle datapath.
//  Optional iterative shifter for shift codes.
// PARAMETERS
//  WIDTH   32  operand/result width in bits
//  SHW     5   shift-amount width; must equal $clog2(WIDTH)
// PORTS
//  clk         in   1      single clock; all state changes on its rising edge
//  rst_n       in   1      synchronous, active-low reset
//  in_valid    in   1      operands + alu_ctrl valid
//  in_ready    out  1      unit can accept an operation this cycle
//  alu_ctrl    in   3      000 add, 001 sub, 010 and, 011 or, 101 slt, 100 sll*, 110 srl*, 111 illegal
//  op_a        in   WIDTH  operand A
//  op_b        in   WIDTH  operand B; shift amount = op_b[SHW-1:0]
//  out_valid   out  1      result/flags valid
//  out_ready   in   1      downstream accepts result
//  result      out  WIDTH  registered result
//  zero        out  1      registered: result == 0
//  illegal     out  1      registered: alu_ctrl had no implementation
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, out_valid=0, result=0, zero=0, illegal=0, shift counter=0.
//  - Reset aborts any in-flight operation, including mid-shift; the aborted result is never presented.
//  - FSM states and transitions:
//    - IDLE: in_ready=1; on in_valid -> DONE (1-cycle op) or SHIFT (shift op, amount != 0).
//    - SHIFT: in_ready=0; each cycle shifts the working register by 1 bit and decrements the count;
//      count==1 -> DONE.
//    - DONE: out_valid=1.
//      - out_ready=0: stay in DONE; result, zero and illegal must not change.
//      - out_ready=1 and in_valid=0: -> IDLE.
//      - out_ready=1 and in_valid=1: accept the new op in the same cycle (in_ready=1) -> DONE or SHIFT.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready); combinational. Forced 0 while rst_n=0.
//  - Latency:
//    - 1-cycle ops: op accepted at edge N, out_valid visible after edge N.
//      Back-to-back throughput is 1/cycle while out_ready=1.
//    - Shift by k>0: out_valid after edge N+k. Shift by 0: behaves as a 1-cycle op, result=op_a.
//  - Arithmetic:
//    - add/sub wrap modulo 2^WIDTH; no carry or overflow output.
//    - slt: signed compare; result = {WIDTH-1 zeros, ($signed(op_a) < $signed(op_b))}.
//    - sll/srl: logical shifts; zero fill.
//  - zero is computed from the final result value, including illegal ops (result 0 -> zero=1).
//  - Illegal code: result=0, illegal=1, latency 1.
//  - Handshake rules:
//    - op_a, op_b and alu_ctrl are sampled only on the in_valid & in_ready edge.
//    - Later changes to these inputs must not affect an in-flight op.
// CONFIGURATION
//  ALU_EXEC_SHIFT_EN defined:
//   - 100 = sll and 110 = srl, executed iteratively in the SHIFT state.
//  ALU_EXEC_SHIFT_EN undefined:
//   - SHIFT state and shift counter are not built.
//   - 100 and 110 are treated as illegal (result=0, illegal=1, latency 1).
// TESTING
//  T1 add:
//   - Stimulus: ctrl=000, a=5, b=3, out_ready=1.
//   - Response: result=8, zero=0, illegal=0, out_valid one edge after accept.
//  T2 sub/zero:
//   - Stimulus: ctrl=001, a=3, b=3.
//   - Response: result=0, zero=1. Then a=0, b=1 -> result=32'hFFFF_FFFF, zero=0.
//  T3 slt signed:
//   - Stimulus: ctrl=101, a=32'hFFFF_FFFF, b=1.
//   - Response: result=1. Then a=1, b=32'hFFFF_FFFF -> result=0.
//  T4 back-pressure:
//   - Stimulus: and a=F0, b=3C with out_ready=0 for 4 cycles, inputs changed meanwhile.
//   - Response: result=30 held, in_ready=0, out_valid=1; a new op is accepted on the out_ready=1 edge.
//  T5 shift (ALU_EXEC_SHIFT_EN):
//   - Stimulus: ctrl=100, a=1, b=4.
//   - Response: out_valid 4 edges after accept, result=16.
//   - Without the macro: result=0, illegal=1 after 1 edge.
//  T6 reset mid-op:
//   - Stimulus: start srl a=80000000, b=31; pull rst_n=0 at cycle 3.
//   - Response: next edge out_valid=0, result=0, in_ready=1 once rst_n=1; no stale result is presented.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU stage with valid/ready on input and output.
// Define ALU_EXEC_SHIFT_EN to build the iterative sll/srl shifter.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  if (SHW != $clog2(WIDTH)) begin : g_chk
    $error("SHW must equal clog2(WIDTH)");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;
  logic             accept;

  logic is_add, is_sub, is_and, is_or, is_slt;
  assign is_add = (alu_ctrl == 3'b000);
  assign is_sub = (alu_ctrl == 3'b001);
  assign is_and = (alu_ctrl == 3'b010);
  assign is_or  = (alu_ctrl == 3'b011);
  assign is_slt = (alu_ctrl == 3'b101);

`ifdef ALU_EXEC_SHIFT_EN
  logic             is_sll, is_srl;
  logic [SHW-1:0]   amt;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] sh_nxt;

  assign is_sll = (alu_ctrl == 3'b100);
  assign is_srl = (alu_ctrl == 3'b110);
  assign amt    = op_b[SHW-1:0];
  // dir_q=1 selects a right shift
  assign sh_nxt = dir_q ? (res_q >> 1) : (res_q << 1);
`endif

  logic [WIDTH-1:0] op_res;
  logic             op_ill;

  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    unique case (1'b1)
      is_add: op_res = op_a + op_b;
      is_sub: op_res = op_a - op_b;
      is_and: op_res = op_a & op_b;
      is_or:  op_res = op_a | op_b;
      is_slt: op_res = {{(WIDTH-1){1'b0}},
                        ($signed(op_a) < $signed(op_b))};
`ifdef ALU_EXEC_SHIFT_EN
      // amount 0 completes here; others iterate
      is_sll, is_srl: op_res = op_a;
`endif
      default: op_ill = 1'b1;
    endcase
  end

  assign in_ready  = rst_n &
                     ((state_q == IDLE) |
                      ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign zero      = zero_q;
  assign illegal   = ill_q;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
`ifdef ALU_EXEC_SHIFT_EN
    cnt_d   = cnt_q;
    dir_d   = dir_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready)
          state_d = IDLE;
        if (accept) begin
          state_d = DONE;
          res_d   = op_res;
          zero_d  = (op_res == '0);
          ill_d   = op_ill;
`ifdef ALU_EXEC_SHIFT_EN
          if ((is_sll | is_srl) && (amt != '0)) begin
            state_d = SHIFT;
            res_d   = op_a;
            zero_d  = 1'b0;
            ill_d   = 1'b0;
            cnt_d   = amt;
            dir_d   = is_srl;
          end
`endif
        end
      end
`ifdef ALU_EXEC_SHIFT_EN
      SHIFT: begin
        res_d = sh_nxt;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
          zero_d  = (sh_nxt == '0);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
      cnt_q   <= '0;
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
`ifdef ALU_EXEC_SHIFT_EN
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
`endif
    end
  end

endmodule
